// File: rtl/hazard_ctrl_mc_pkg.sv
// hazard_pkg: shared forward-select codes, MDU state and stall-cause enums for hazard_ctrl_mc.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {MDU_IDLE, MDU_BUSY} mduState_t;

    typedef enum logic [2:0] {CAUSE_NONE, CAUSE_MEM, CAUSE_LW, CAUSE_BR, CAUSE_MDU} stallCause_t;

    // M outranks W: it holds the younger result.
    function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
        return hitM ? FWD_M : hitW ? FWD_W : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// hazard_ctrl_mc_if: pipeline <-> hazard unit signal bundle; perf ports exist only with HAZ_PERF_CNT_EN.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic BranchD, JumpD;
    logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic MduUseD, MduStartE, DmemReqM, DmemReady;
    logic StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic MduBusy, MduDone;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] PerfLwStall, PerfBrStall, PerfMduStall, PerfMemWait;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input PerfLwStall, PerfBrStall, PerfMduStall, PerfMemWait,
`endif
        output BranchD, JumpD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output MduUseD, MduStartE, DmemReqM, DmemReady,
        input StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD,
        input ForwardAE, ForwardBE, MduBusy, MduDone
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output PerfLwStall, PerfBrStall, PerfMduStall, PerfMemWait,
`endif
        input BranchD, JumpD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input MduUseD, MduStartE, DmemReqM, DmemReady,
        output StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD,
        output ForwardAE, ForwardBE, MduBusy, MduDone
    );

endinterface

// File: rtl/hazard_ctrl_mc_mdu_scoreboard.sv
// mdu_scoreboard: tracks the multi-cycle MUL/DIV unit; busy for MDU_LAT cycles, MduDone in the last one.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic MduBusy,
    output logic MduDone
);

    localparam int CW = $clog2(MDU_LAT);

    mduState_t state;
    logic [CW-1:0] cnt;

    // The MDU keeps counting through memory waits; only acceptance is gated by the caller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            MduBusy <= 1'b0;
            MduDone <= 1'b0;
        end else if (state == MDU_IDLE) begin
            MduDone <= 1'b0;
            if (start) begin
                state   <= MDU_BUSY;
                cnt     <= CW'(MDU_LAT - 1);
                MduBusy <= 1'b1;
            end
        end else if (cnt == '0) begin
            state   <= MDU_IDLE;
            MduBusy <= 1'b0;
            MduDone <= 1'b0;
        end else begin
            cnt     <= cnt - 1'b1;
            MduDone <= cnt == CW'(1);
        end
    end

    startWhileBusy: assert property (@(posedge clk) disable iff (!rst_n) !(start && MduBusy));

endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: forwarding and stall/flush control for the 5-stage pipeline with dmem wait and MDU scoreboard.
// Optional per-cause stall counters under `define HAZ_PERF_CNT_EN.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 32
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input logic clk,
    input logic rst_n,
    hazard_ctrl_mc_if.slave hz
);

    localparam logic [REG_AW-1:0] ZERO = '0;

    logic lwStall, brStall, mduStall, memWait, hazStall, mduStart;

    function automatic logic hit(input logic we, input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
        return we && src != ZERO && dst == src;
    endfunction

    assign hz.ForwardAE = fwdSel(hit(hz.RegWriteM, hz.WriteRegM, hz.RsE), hit(hz.RegWriteW, hz.WriteRegW, hz.RsE));
    assign hz.ForwardBE = fwdSel(hit(hz.RegWriteM, hz.WriteRegM, hz.RtE), hit(hz.RegWriteW, hz.WriteRegW, hz.RtE));
    assign hz.ForwardAD = hit(hz.RegWriteM && !hz.MemtoRegM, hz.WriteRegM, hz.RsD);
    assign hz.ForwardBD = hit(hz.RegWriteM && !hz.MemtoRegM, hz.WriteRegM, hz.RtD);

    assign lwStall  = hit(hz.MemtoRegE && hz.RegWriteE, hz.WriteRegE, hz.RsD)
                    | hit(hz.MemtoRegE && hz.RegWriteE, hz.WriteRegE, hz.RtD);
    assign brStall  = hz.BranchD && (hit(hz.RegWriteE, hz.WriteRegE, hz.RsD) | hit(hz.RegWriteE, hz.WriteRegE, hz.RtD)
                    | hit(hz.MemtoRegM, hz.WriteRegM, hz.RsD) | hit(hz.MemtoRegM, hz.WriteRegM, hz.RtD));
    assign mduStall = hz.MduUseD && (hz.MduBusy || hz.MduStartE);
    assign memWait  = hz.DmemReqM && !hz.DmemReady;
    assign hazStall = lwStall | brStall | mduStall;

    // A memory wait freezes F..M outright and masks every other hazard.
    assign hz.StallF = memWait | hazStall;
    assign hz.StallD = memWait | hazStall;
    assign hz.StallE = memWait;
    assign hz.StallM = memWait;
    assign hz.FlushW = memWait;
    assign hz.FlushE = !memWait && (hazStall || hz.JumpD);

    assign mduStart = hz.MduStartE && !memWait;

    mdu_scoreboard #(.MDU_LAT(MDU_LAT)) mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mduStart),
        .MduBusy (hz.MduBusy),
        .MduDone (hz.MduDone)
    );

`ifdef HAZ_PERF_CNT_EN
    stallCause_t cause;

    assign cause = memWait ? CAUSE_MEM : lwStall ? CAUSE_LW : brStall ? CAUSE_BR : mduStall ? CAUSE_MDU : CAUSE_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.PerfLwStall  <= '0;
            hz.PerfBrStall  <= '0;
            hz.PerfMduStall <= '0;
            hz.PerfMemWait  <= '0;
        end else begin
            if (cause == CAUSE_LW && !(&hz.PerfLwStall)) hz.PerfLwStall <= hz.PerfLwStall + 1'b1;
            if (cause == CAUSE_BR && !(&hz.PerfBrStall)) hz.PerfBrStall <= hz.PerfBrStall + 1'b1;
            if (cause == CAUSE_MDU && !(&hz.PerfMduStall)) hz.PerfMduStall <= hz.PerfMduStall + 1'b1;
            if (cause == CAUSE_MEM && !(&hz.PerfMemWait)) hz.PerfMemWait <= hz.PerfMemWait + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed plan cases then random traffic, checked by a queue-based scoreboard.
module tb_hazard_ctrl_mc;

    localparam int AW  = 5;
    localparam int LAT = 4;

    typedef struct packed {
        logic BranchD, JumpD;
        logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
        logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
        logic MduUseD, MduStartE, DmemReqM, DmemReady;
    } stim_t;

    typedef struct packed {
        logic StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD;
        logic [1:0] ForwardAE, ForwardBE;
        logic MduBusy, MduDone;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int vectors = 0;
    int miscompares = 0;
    int remain = 0;
    logic acceptPrev = 0;
    exp_t q[$];
    stim_t s;

    hazard_ctrl_mc_if #(.REG_AW(AW)) hz ();

    hazard_ctrl_mc #(.REG_AW(AW), .MDU_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic bit writes(input bit we, input logic [AW-1:0] dst, input logic [AW-1:0] src);
        return we && src != 0 && dst == src;
    endfunction

    function automatic exp_t model(input stim_t v, input int rem);
        exp_t e;
        bit lw, br, mdu, wait_;
        e = '0;
        e.ForwardAE = writes(v.RegWriteM, v.WriteRegM, v.RsE) ? 2'b10 : writes(v.RegWriteW, v.WriteRegW, v.RsE) ? 2'b01 : 2'b00;
        e.ForwardBE = writes(v.RegWriteM, v.WriteRegM, v.RtE) ? 2'b10 : writes(v.RegWriteW, v.WriteRegW, v.RtE) ? 2'b01 : 2'b00;
        e.ForwardAD = writes(v.RegWriteM && !v.MemtoRegM, v.WriteRegM, v.RsD);
        e.ForwardBD = writes(v.RegWriteM && !v.MemtoRegM, v.WriteRegM, v.RtD);
        lw = v.MemtoRegE && v.RegWriteE && v.WriteRegE != 0 && (v.WriteRegE == v.RsD || v.WriteRegE == v.RtD);
        br = v.BranchD && ((v.RegWriteE && v.WriteRegE != 0 && (v.WriteRegE == v.RsD || v.WriteRegE == v.RtD))
             || (v.MemtoRegM && v.WriteRegM != 0 && (v.WriteRegM == v.RsD || v.WriteRegM == v.RtD)));
        mdu = v.MduUseD && (rem > 0 || v.MduStartE);
        wait_ = v.DmemReqM && !v.DmemReady;
        e.MduBusy = rem > 0;
        e.MduDone = rem == 1;
        if (wait_) begin
            {e.StallF, e.StallD, e.StallE, e.StallM, e.FlushW} = '1;
        end else if (lw || br || mdu) begin
            {e.StallF, e.StallD, e.FlushE} = '1;
        end else begin
            e.FlushE = v.JumpD;
        end
        return e;
    endfunction

    // One clock: advance the MDU model over the edge, drive the new inputs, queue the expected outputs.
    task automatic applyCycle(input stim_t v, input logic rv);
        exp_t e;
        @(posedge clk);
        if (remain > 0) remain--;
        else if (acceptPrev) remain = LAT;
        #1;
        if (remain != 0) v.MduStartE = 0;
        rst_n = rv;
        if (!rv) remain = 0;
        {hz.BranchD, hz.JumpD, hz.RsD, hz.RtD, hz.RsE, hz.RtE, hz.WriteRegE, hz.WriteRegM, hz.WriteRegW,
         hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.MemtoRegM,
         hz.MduUseD, hz.MduStartE, hz.DmemReqM, hz.DmemReady} = v;
        e = model(v, remain);
        acceptPrev = rv && v.MduStartE && !e.StallE;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0b, expected %0b", name, vectors, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            vectors++;
            chk("StallF", {1'b0, hz.StallF}, {1'b0, e.StallF});
            chk("StallD", {1'b0, hz.StallD}, {1'b0, e.StallD});
            chk("StallE", {1'b0, hz.StallE}, {1'b0, e.StallE});
            chk("StallM", {1'b0, hz.StallM}, {1'b0, e.StallM});
            chk("FlushE", {1'b0, hz.FlushE}, {1'b0, e.FlushE});
            chk("FlushW", {1'b0, hz.FlushW}, {1'b0, e.FlushW});
            chk("ForwardAD", {1'b0, hz.ForwardAD}, {1'b0, e.ForwardAD});
            chk("ForwardBD", {1'b0, hz.ForwardBD}, {1'b0, e.ForwardBD});
            chk("ForwardAE", hz.ForwardAE, e.ForwardAE);
            chk("ForwardBE", hz.ForwardBE, e.ForwardBE);
            chk("MduBusy", {1'b0, hz.MduBusy}, {1'b0, e.MduBusy});
            chk("MduDone", {1'b0, hz.MduDone}, {1'b0, e.MduDone});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors checked", vectors);
        $fatal(1);
    end

    initial begin
        s = '0;
        {hz.BranchD, hz.JumpD, hz.RsD, hz.RtD, hz.RsE, hz.RtE, hz.WriteRegE, hz.WriteRegM, hz.WriteRegW,
         hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.MemtoRegM,
         hz.MduUseD, hz.MduStartE, hz.DmemReqM, hz.DmemReady} = s;
        applyCycle(s, 0);
        applyCycle(s, 0);
        applyCycle(s, 1);
        // forwarding priority and the zero register
        s.RsE = 3; s.WriteRegM = 3; s.RegWriteM = 1; s.WriteRegW = 3; s.RegWriteW = 1; applyCycle(s, 1);
        s.RegWriteM = 0; applyCycle(s, 1);
        s.RsE = 0; applyCycle(s, 1);
        s.RtE = 3; applyCycle(s, 1);
        // load-use
        s = '0; s.MemtoRegE = 1; s.RegWriteE = 1; s.WriteRegE = 8; s.RtD = 8; applyCycle(s, 1);
        s.WriteRegE = 0; s.RtD = 0; applyCycle(s, 1);
        // branch: producer in E, then in M as an ALU result
        s = '0; s.BranchD = 1; s.RegWriteE = 1; s.WriteRegE = 5; s.RsD = 5; applyCycle(s, 1);
        s.RegWriteE = 0; s.WriteRegE = 0; s.RegWriteM = 1; s.WriteRegM = 5; applyCycle(s, 1);
        s.MemtoRegM = 1; applyCycle(s, 1);
        // memory wait masks load-use and jump
        s = '0; s.MemtoRegE = 1; s.RegWriteE = 1; s.WriteRegE = 8; s.RsD = 8; s.JumpD = 1; s.DmemReqM = 1;
        repeat (3) applyCycle(s, 1);
        s.DmemReady = 1; applyCycle(s, 1);
        s = '0; s.JumpD = 1; applyCycle(s, 1);
        // MDU run with a dependent D instruction
        s = '0; s.MduStartE = 1; applyCycle(s, 1);
        s = '0; applyCycle(s, 1);
        s.MduUseD = 1; repeat (5) applyCycle(s, 1);
        s = '0; repeat (2) applyCycle(s, 1);
        // reset in the middle of an MDU operation
        s.MduStartE = 1; applyCycle(s, 1);
        s = '0; repeat (2) applyCycle(s, 1);
        repeat (2) applyCycle(s, 0);
        repeat (6) applyCycle(s, 1);
        for (int i = 0; i < 600; i++) begin
            s.BranchD   = $urandom_range(0, 3) == 0;
            s.JumpD     = $urandom_range(0, 5) == 0;
            s.RsD       = AW'($urandom_range(0, 3));
            s.RtD       = AW'($urandom_range(0, 3));
            s.RsE       = AW'($urandom_range(0, 3));
            s.RtE       = AW'($urandom_range(0, 3));
            s.WriteRegE = AW'($urandom_range(0, 3));
            s.WriteRegM = AW'($urandom_range(0, 3));
            s.WriteRegW = AW'($urandom_range(0, 3));
            s.RegWriteE = $urandom_range(0, 1) == 1;
            s.RegWriteM = $urandom_range(0, 1) == 1;
            s.RegWriteW = $urandom_range(0, 1) == 1;
            s.MemtoRegE = $urandom_range(0, 2) == 0;
            s.MemtoRegM = $urandom_range(0, 2) == 0;
            s.MduUseD   = $urandom_range(0, 3) == 0;
            s.MduStartE = $urandom_range(0, 5) == 0;
            s.DmemReqM  = $urandom_range(0, 3) == 0;
            s.DmemReady = $urandom_range(0, 1) == 1;
            applyCycle(s, $urandom_range(0, 99) != 0);
        end
        s = '0;
        applyCycle(s, 1);
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
